// File: rtl/i17126_seq_core.sv
// Two-input core: registered XOR of the sampled inputs, forced high
// when the samples walk 00->01->10->11 on consecutive edges.
module i17126_seq_core #(
  parameter bit SEQ_DETECT_EN = 1'b1
) (
  input  logic CK,
  input  logic reset,
  input  logic n0,
  input  logic n1,
  output logic output_single
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_A    = 2'd1,
    S_B    = 2'd2,
    S_C    = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_s;
  logic       w_hit;
  logic       r_out;

  assign w_s = {n1, n0};

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A fresh 00 always restarts the walk, even from C.
  always_comb begin
    w_next = S_IDLE;
    w_hit  = 1'b0;
    if (SEQ_DETECT_EN) begin
      unique case (1'b1)
        (w_s == 2'b00):
          w_next = S_A;
        (r_state == S_A && w_s == 2'b01):
          w_next = S_B;
        (r_state == S_B && w_s == 2'b10):
          w_next = S_C;
        (r_state == S_C && w_s == 2'b11):
          w_hit = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_out <= 1'b0;
    end else begin
      r_out <= (n0 ^ n1) | w_hit;
    end
  end

  assign output_single = r_out;

endmodule

// File: tb/tb_i17126_seq_core.sv
// Bench for i17126_seq_core: sample-history model checked every cycle
// plus literal expectations for the directed sequences.
module tb_i17126_seq_core;

  logic CK = 1'b0;
  logic reset = 1'b1;
  logic n0 = 1'b0;
  logic n1 = 1'b0;
  logic out_on;
  logic out_off;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  i17126_seq_core #(.SEQ_DETECT_EN(1'b1)) u_on (
    .CK(CK), .reset(reset), .n0(n0), .n1(n1),
    .output_single(out_on)
  );

  i17126_seq_core #(.SEQ_DETECT_EN(1'b0)) u_off (
    .CK(CK), .reset(reset), .n0(n0), .n1(n1),
    .output_single(out_off)
  );

  always #5 CK = ~CK;

  // Model: last three post-reset samples, newest in h[0].
  logic [1:0] h [3];
  int         m_cnt = 0;
  logic       m_on = 1'b0;
  logic       m_off = 1'b0;

  always @(posedge CK or negedge reset) begin
    if (!reset) begin
      m_cnt <= 0;
      m_on  <= 1'b0;
      m_off <= 1'b0;
    end else begin
      m_off <= n0 ^ n1;
      m_on  <= (n0 ^ n1) |
               (m_cnt >= 3 && h[2] == 2'b00 && h[1] == 2'b01 &&
                h[0] == 2'b10 && {n1, n0} == 2'b11);
      h[2]  <= h[1];
      h[1]  <= h[0];
      h[0]  <= {n1, n0};
      m_cnt <= (m_cnt < 3) ? m_cnt + 1 : 3;
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CK) begin
    if (chk_en) begin
      chk("model_on", out_on, m_on);
      chk("model_off", out_off, m_off);
    end
  end

  // Drive a sample, let one edge take it, then look at the outputs.
  task automatic step(input logic [1:0] s);
    @(negedge CK);
    {n1, n0} = s;
    @(posedge CK);
    #1;
  endtask

  initial begin
    // 1: reset held, inputs toggling
    reset = 1'b0;
    #6 chk_en = 1'b1;
    step(2'b01);
    chk("rst_hold0", out_on, 1'b0);
    step(2'b10);
    chk("rst_hold1", out_on, 1'b0);
    step(2'b11);
    chk("rst_hold2", out_off, 1'b0);
    @(negedge CK);
    reset = 1'b1;
    step(2'b01);
    chk("post_rst", out_on, 1'b1);
    #1 reset = 1'b0;
    #1 chk("async_rst", out_on, 1'b0);
    chk("async_rst_off", out_off, 1'b0);
    @(negedge CK);
    reset = 1'b1;

    // 2: truth table after a non-00 sample
    step(2'b11);
    step(2'b01); chk("tt01", out_on, 1'b1);
    step(2'b10); chk("tt10", out_on, 1'b1);
    step(2'b00); chk("tt00", out_on, 1'b0);
    step(2'b11); chk("tt11", out_on, 1'b0);

    // 3 + 6: full sequence, detector on and off
    step(2'b00); chk("seq0", out_on, 1'b0);
    chk("off0", out_off, 1'b0);
    step(2'b01); chk("seq1", out_on, 1'b1);
    chk("off1", out_off, 1'b1);
    step(2'b10); chk("seq2", out_on, 1'b1);
    chk("off2", out_off, 1'b1);
    step(2'b11); chk("seq_hit", out_on, 1'b1);
    chk("off_nohit", out_off, 1'b0);

    // 4a: overlap restart
    step(2'b00); step(2'b01); step(2'b00);
    step(2'b01); step(2'b10); step(2'b11);
    chk("overlap_hit", out_on, 1'b1);
    // 4b: broken walk
    step(2'b00); step(2'b10); step(2'b11);
    chk("break_nohit", out_on, 1'b0);
    // 4c: break at the last sample, then no stale progress
    step(2'b00); step(2'b01); step(2'b10); step(2'b01);
    chk("break_xor", out_on, 1'b1);
    step(2'b10); step(2'b11);
    chk("idle_after_break", out_on, 1'b0);
    // back-to-back hits via overlap restart
    step(2'b00); step(2'b01); step(2'b10); step(2'b11);
    chk("hit_a", out_on, 1'b1);
    step(2'b00); step(2'b01); step(2'b10); step(2'b11);
    chk("hit_b", out_on, 1'b1);

    // 5: reset mid-sequence
    step(2'b00); step(2'b01); step(2'b10);
    @(negedge CK);
    reset = 1'b0;
    @(negedge CK);
    reset = 1'b1;
    step(2'b11);
    chk("rst_mid_seq", out_on, 1'b0);

    step(2'b00);
    repeat (2) @(negedge CK);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
